// File: rtl/rf_access_ctrl_if.sv
// Command, response and register-file port bundle for rf_access_ctrl.
interface rf_access_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [2:0] cmd_addr_a;
   logic [2:0] cmd_addr_b;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data1;
   logic [7:0] rsp_data2;
   logic       rf_write_en;
   logic [2:0] rf_write_add;
   logic [7:0] rf_write_data;
   logic [2:0] rf_read_add1;
   logic [2:0] rf_read_add2;
   logic [7:0] rf_read_data1;
   logic [7:0] rf_read_data2;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
             rf_read_data1, rf_read_data2,
      output cmd_ready, rsp_valid, rsp_data1, rsp_data2, rf_write_en, rf_write_add,
             rf_write_data, rf_read_add1, rf_read_add2
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
             rf_read_data1, rf_read_data2,
      input  cmd_ready, rsp_valid, rsp_data1, rsp_data2, rf_write_en, rf_write_add,
             rf_write_data, rf_read_add1, rf_read_add2
   );
endinterface

// File: rtl/rf_access_ctrl.sv
// Sole master of an 8x8 register file: WRITE/READ/CLEAR/COPY in, one response beat out.
// rsp_valid after acceptance: WRITE/READ 2, COPY 3, CLEAR 9 cycles; holds in RESP while rsp_ready is low.
module rf_access_ctrl (
   input  logic            clk,
   input  logic            rst,
   rf_access_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WR, RD, CLR, CPW, RESP} state_t;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_COPY  = 2'b11;

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [2:0] addr_b_q, addr_b_d;
   logic [7:0] data_q, data_d;
   logic [2:0] cnt_q, cnt_d;
   logic       rf_write_en_q, rf_write_en_d;
   logic [2:0] rf_write_add_q, rf_write_add_d;
   logic [7:0] rf_write_data_q, rf_write_data_d;
   logic [2:0] rf_read_add1_q, rf_read_add1_d;
   logic [2:0] rf_read_add2_q, rf_read_add2_d;
   logic [7:0] rsp_data1_q, rsp_data1_d;
   logic [7:0] rsp_data2_q, rsp_data2_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         op_q            <= '0;
         addr_b_q        <= '0;
         data_q          <= '0;
         cnt_q           <= '0;
         rf_write_en_q   <= 1'b0;
         rf_write_add_q  <= '0;
         rf_write_data_q <= '0;
         rf_read_add1_q  <= '0;
         rf_read_add2_q  <= '0;
         rsp_data1_q     <= '0;
         rsp_data2_q     <= '0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         addr_b_q        <= addr_b_d;
         data_q          <= data_d;
         cnt_q           <= cnt_d;
         rf_write_en_q   <= rf_write_en_d;
         rf_write_add_q  <= rf_write_add_d;
         rf_write_data_q <= rf_write_data_d;
         rf_read_add1_q  <= rf_read_add1_d;
         rf_read_add2_q  <= rf_read_add2_d;
         rsp_data1_q     <= rsp_data1_d;
         rsp_data2_q     <= rsp_data2_d;
      end
   end

   // Port values are computed for the state being entered, so every rf_* output is a flop.
   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      addr_b_d        = addr_b_q;
      data_d          = data_q;
      cnt_d           = cnt_q;
      rf_write_en_d   = 1'b0;
      rf_write_add_d  = '0;
      rf_write_data_d = '0;
      rf_read_add1_d  = '0;
      rf_read_add2_d  = '0;
      rsp_data1_d     = '0;
      rsp_data2_d     = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               op_d     = bus.cmd_op;
               addr_b_d = bus.cmd_addr_b;
               data_d   = bus.cmd_data;
               case (bus.cmd_op)
                  OP_WRITE: begin
                     state_d         = WR;
                     rf_write_en_d   = 1'b1;
                     rf_write_add_d  = bus.cmd_addr_a;
                     rf_write_data_d = bus.cmd_data;
                  end
                  OP_READ: begin
                     state_d        = RD;
                     rf_read_add1_d = bus.cmd_addr_a;
                     rf_read_add2_d = bus.cmd_addr_b;
                  end
                  OP_CLEAR: begin
                     state_d       = CLR;
                     rf_write_en_d = 1'b1;
                     cnt_d         = '0;
                  end
                  default: begin
                     state_d        = RD;
                     rf_read_add1_d = bus.cmd_addr_a;
                  end
               endcase
            end
         end
         WR: begin
            state_d     = RESP;
            rsp_data1_d = data_q;
         end
         RD: begin
            if (op_q == OP_COPY) begin
               state_d         = CPW;
               rf_write_en_d   = 1'b1;
               rf_write_add_d  = addr_b_q;
               rf_write_data_d = bus.rf_read_data1;
            end else begin
               state_d     = RESP;
               rsp_data1_d = bus.rf_read_data1;
               rsp_data2_d = bus.rf_read_data2;
            end
         end
         CLR: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = RESP;
            end else begin
               rf_write_en_d  = 1'b1;
               rf_write_add_d = cnt_d;
            end
         end
         CPW: begin
            state_d     = RESP;
            rsp_data1_d = rf_write_data_q;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end else begin
               rsp_data1_d = rsp_data1_q;
               rsp_data2_d = rsp_data2_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cmd_ready     = (state_q == IDLE);
   assign bus.rsp_valid     = (state_q == RESP);
   assign bus.rsp_data1     = rsp_data1_q;
   assign bus.rsp_data2     = rsp_data2_q;
   assign bus.rf_write_en   = rf_write_en_q;
   assign bus.rf_write_add  = rf_write_add_q;
   assign bus.rf_write_data = rf_write_data_q;
   assign bus.rf_read_add1  = rf_read_add1_q;
   assign bus.rf_read_add2  = rf_read_add2_q;
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl with a behavioural 8x8 register file and a response scoreboard.
module tb_rf_access_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rf_access_ctrl_if bus ();
   rf_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   // Register file: synchronous write, combinational reads.
   logic [7:0] mem [8];
   always @(posedge clk) if (bus.rf_write_en) mem[bus.rf_write_add] <= bus.rf_write_data;
   assign bus.rf_read_data1 = mem[bus.rf_read_add1];
   assign bus.rf_read_data2 = mem[bus.rf_read_add2];

   typedef struct packed {logic [7:0] d1; logic [7:0] d2;} rsp_t;

   int         total = 0;
   int         bad   = 0;
   rsp_t       exp_q [$];
   logic [7:0] ref_mem [8];
   logic [2:0] wr_a [$];
   logic [7:0] wr_d [$];
   logic [2:0] rd1_seen, rd2_seen;
   int         lat_seen;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   // Issue one command, then check latency, write trace, read addresses and response.
   task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [7:0] d, input int stall);
      rsp_t       exp_r;
      int         exp_lat;
      int         exp_wr;
      logic [7:0] cp_val;
      logic [2:0] ea;
      logic [7:0] ed;
      cp_val = 8'h00;
      case (op)
         2'b00: begin exp_r = {d, 8'h00}; exp_lat = 2; exp_wr = 1; ref_mem[a] = d; end
         2'b01: begin exp_r = {ref_mem[a], ref_mem[b]}; exp_lat = 2; exp_wr = 0; end
         2'b10: begin
            exp_r = 16'h0000; exp_lat = 9; exp_wr = 8;
            for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
         end
         default: begin
            cp_val = ref_mem[a]; exp_r = {cp_val, 8'h00}; exp_lat = 3; exp_wr = 1;
            ref_mem[b] = cp_val;
         end
      endcase
      exp_q.push_back(exp_r);
      wr_a.delete(); wr_d.delete();
      lat_seen = 0; rd1_seen = '0; rd2_seen = '0;
      bus.rsp_ready  = (stall == 0);
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = op;
      bus.cmd_addr_a = a;
      bus.cmd_addr_b = b;
      bus.cmd_data   = d;
      total++;
      if (bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL cmd_ready_idle: got %b want 1", bus.cmd_ready);
      end
      @(posedge clk);
      #1;
      // Scramble fields after acceptance; the controller must have registered them.
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'($urandom_range(0, 3));
      bus.cmd_addr_a = 3'($urandom_range(0, 7));
      bus.cmd_addr_b = 3'($urandom_range(0, 7));
      bus.cmd_data   = 8'($urandom_range(0, 255));
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.rf_write_en === 1'b1) begin
            wr_a.push_back(bus.rf_write_add);
            wr_d.push_back(bus.rf_write_data);
         end
         if (k == 1) begin rd1_seen = bus.rf_read_add1; rd2_seen = bus.rf_read_add2; end
         if (bus.rsp_valid === 1'b1) begin lat_seen = k; break; end
      end
      total++;
      if (lat_seen != exp_lat) begin
         bad++; $display("FAIL latency op=%0d: got %0d want %0d (0 = timeout)", op, lat_seen, exp_lat);
      end
      exp_r = exp_q.pop_front();
      total++;
      if ({bus.rsp_data1, bus.rsp_data2} !== exp_r) begin
         bad++; $display("FAIL rsp_data op=%0d: got %h/%h want %h/%h", op,
                         bus.rsp_data1, bus.rsp_data2, exp_r.d1, exp_r.d2);
      end
      total++;
      if (wr_a.size() != exp_wr) begin
         bad++; $display("FAIL write_count op=%0d: got %0d want %0d", op, wr_a.size(), exp_wr);
      end else begin
         for (int i = 0; i < exp_wr; i++) begin
            ea = (op == 2'b00) ? a : (op == 2'b11) ? b : 3'(i);
            ed = (op == 2'b00) ? d : (op == 2'b11) ? cp_val : 8'h00;
            total++;
            if (wr_a[i] !== ea || wr_d[i] !== ed) begin
               bad++; $display("FAIL write_beat%0d op=%0d: got %0d/%h want %0d/%h",
                               i, op, wr_a[i], wr_d[i], ea, ed);
            end
         end
      end
      if (op == 2'b01 || op == 2'b11) begin
         total++;
         if (rd1_seen !== a) begin
            bad++; $display("FAIL read_add1 op=%0d: got %0d want %0d", op, rd1_seen, a);
         end
      end
      if (op == 2'b01) begin
         total++;
         if (rd2_seen !== b) begin
            bad++; $display("FAIL read_add2: got %0d want %0d", rd2_seen, b);
         end
      end
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         total++;
         if (bus.rsp_valid !== 1'b1 || {bus.rsp_data1, bus.rsp_data2} !== exp_r ||
             bus.cmd_ready !== 1'b0 || bus.rf_write_en !== 1'b0) begin
            bad++; $display("FAIL stall_hold cyc=%0d: got v=%b d=%h/%h rdy=%b we=%b want v=1 d=%h/%h rdy=0 we=0",
                            s, bus.rsp_valid, bus.rsp_data1, bus.rsp_data2, bus.cmd_ready,
                            bus.rf_write_en, exp_r.d1, exp_r.d2);
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data1 !== 8'h00) begin
         bad++; $display("FAIL post_handshake op=%0d: got rdy=%b v=%b d1=%h want rdy=1 v=0 d1=00",
                         op, bus.cmd_ready, bus.rsp_valid, bus.rsp_data1);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rf_write_en !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl: got rdy=%b v=%b we=%b want 1/0/0",
                         bus.cmd_ready, bus.rsp_valid, bus.rf_write_en);
      end
      total++;
      if (bus.rf_write_add !== 3'd0 || bus.rf_write_data !== 8'h00 || bus.rf_read_add1 !== 3'd0 ||
          bus.rf_read_add2 !== 3'd0 || bus.rsp_data1 !== 8'h00 || bus.rsp_data2 !== 8'h00) begin
         bad++; $display("FAIL reset_data: got wa=%0d wd=%h ra=%0d/%0d rsp=%h/%h want all 0",
                         bus.rf_write_add, bus.rf_write_data, bus.rf_read_add1, bus.rf_read_add2,
                         bus.rsp_data1, bus.rsp_data2);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_release: got rdy=%b v=%b want 1/0", bus.cmd_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_write();
      do_cmd(2'b00, 3'd3, 3'd0, 8'hA5, 0);
   endtask

   task automatic test_read();
      do_cmd(2'b00, 3'd1, 3'd0, 8'h11, 0);
      do_cmd(2'b00, 3'd6, 3'd0, 8'h22, 0);
      do_cmd(2'b01, 3'd1, 3'd6, 8'h00, 0);
   endtask

   task automatic test_clear();
      for (int i = 0; i < 8; i++) do_cmd(2'b00, 3'(i), 3'd0, 8'hFF, 0);
      do_cmd(2'b10, 3'd0, 3'd0, 8'h00, 0);
      do_cmd(2'b01, 3'd0, 3'd7, 8'h00, 0);
      do_cmd(2'b01, 3'd3, 3'd4, 8'h00, 0);
   endtask

   task automatic test_copy();
      do_cmd(2'b00, 3'd2, 3'd0, 8'h5C, 0);
      do_cmd(2'b11, 3'd2, 3'd5, 8'h00, 0);
      do_cmd(2'b01, 3'd5, 3'd5, 8'h00, 0);
      do_cmd(2'b00, 3'd4, 3'd0, 8'h77, 0);
      do_cmd(2'b11, 3'd4, 3'd4, 8'h00, 0);
      do_cmd(2'b01, 3'd4, 3'd2, 8'h00, 0);
   endtask

   task automatic test_stall();
      do_cmd(2'b01, 3'd2, 3'd5, 8'h00, 10);
   endtask

   task automatic test_back_to_back();
      logic [2:0] a;
      for (int n = 0; n < 8; n++) begin
         a = 3'($urandom_range(0, 7));
         do_cmd(2'b00, a, 3'd0, 8'($urandom_range(0, 255)), 0);
         do_cmd(2'b01, a, 3'($urandom_range(0, 7)), 8'h00, 0);
      end
   endtask

   task automatic test_reset_mid_clear();
      int vld_seen;
      for (int i = 0; i < 8; i++) do_cmd(2'b00, 3'(i), 3'd0, 8'hAB, 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b10;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (bus.rf_write_en !== 1'b1 || bus.rf_write_add !== 3'd3) begin
         bad++; $display("FAIL clr_4th_cycle: got we=%b add=%0d want 1/3", bus.rf_write_en, bus.rf_write_add);
      end
      rst = 1'b0;
      #1;
      total++;
      if (bus.rf_write_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 ||
          bus.rf_write_add !== 3'd0) begin
         bad++; $display("FAIL async_reset: got we=%b v=%b rdy=%b add=%0d want 0/0/1/0",
                         bus.rf_write_en, bus.rsp_valid, bus.cmd_ready, bus.rf_write_add);
      end
      // A command offered during reset must not be taken.
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = 2'b00;
      bus.cmd_addr_a = 3'd4;
      bus.cmd_data   = 8'h00;
      vld_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0 || bus.rf_write_en !== 1'b0) vld_seen++;
      end
      bus.cmd_valid = 1'b0;
      rst = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0 || bus.rf_write_en !== 1'b0) vld_seen++;
      end
      total++;
      if (vld_seen != 0) begin
         bad++; $display("FAIL no_response_after_reset: got %0d active cycles want 0", vld_seen);
      end
      for (int i = 0; i < 3; i++) ref_mem[i] = 8'h00;
      do_cmd(2'b01, 3'd0, 3'd1, 8'h00, 0);
      do_cmd(2'b01, 3'd2, 3'd4, 8'h00, 0);
      do_cmd(2'b01, 3'd5, 3'd6, 8'h00, 0);
      do_cmd(2'b01, 3'd7, 3'd7, 8'h00, 0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'b00;
      bus.cmd_addr_a = 3'd0;
      bus.cmd_addr_b = 3'd0;
      bus.cmd_data   = 8'h00;
      bus.rsp_ready  = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_clear();
      test_copy();
      test_stall();
      test_back_to_back();
      test_reset_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
